// File: rtl/bridge_rr_arbiter_ctrl.sv
// Round-robin arbiter/flow controller sharing one bridge request channel among N_MASTER requesters.
// Optional per-master outstanding-credit limiting: define BRIDGE_ARB_CREDIT_LIMIT_EN.
module bridge_rr_arbiter_ctrl #(
  parameter int unsigned N_MASTER        = 16,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BE_WIDTH        = DATA_WIDTH/8,
  parameter int unsigned ID_WIDTH        = N_MASTER,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_MASTER-1:0]            data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
  input  logic [N_MASTER-1:0]            data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
  input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
  output logic [N_MASTER-1:0]            data_gnt_o,
  output logic                           data_req_o,
  output logic [ADDR_WIDTH-1:0]          data_add_o,
  output logic                           data_wen_o,
  output logic [DATA_WIDTH-1:0]          data_wdata_o,
  output logic [BE_WIDTH-1:0]            data_be_o,
  output logic [ID_WIDTH-1:0]            data_ID_o,
  input  logic                           data_gnt_i,
  input  logic                           data_r_valid_i,
  input  logic [ID_WIDTH-1:0]            data_r_ID_i,
  output logic [N_MASTER-1:0]            data_r_valid_o,
  output logic                           err_o
);

  localparam int unsigned IDX_W = $clog2(N_MASTER);

  logic [N_MASTER-1:0] blocked;
  logic [N_MASTER-1:0] elig;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]    rr_win, win;
  logic                lock_q, lock_d;
  logic                err_q, err_d;
  logic                rr_found, lock_hold, lock_drop, req, hs;
  logic                spur_err;

  assign elig      = data_req_i & ~blocked;
  assign lock_hold = lock_q & data_req_i[lock_idx_q];
  assign lock_drop = lock_q & ~data_req_i[lock_idx_q];

  // First eligible index starting at rr_q, wrapping modulo N_MASTER (works for non-power-of-2).
  always_comb begin
    int unsigned idx;
    rr_found = 1'b0;
    rr_win   = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (!rr_found && elig[IDX_W'(idx)]) begin
        rr_found = 1'b1;
        rr_win   = IDX_W'(idx);
      end
    end
  end

  assign win = lock_hold ? lock_idx_q : rr_win;
  assign req = lock_hold | rr_found;
  assign hs  = req & data_gnt_i;

  always_comb begin
    data_req_o   = req;
    data_gnt_o   = '0;
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    data_ID_o    = '0;
    if (req) begin
      data_add_o     = data_add_i[win*ADDR_WIDTH +: ADDR_WIDTH];
      data_wen_o     = data_wen_i[win];
      data_wdata_o   = data_wdata_i[win*DATA_WIDTH +: DATA_WIDTH];
      data_be_o      = data_be_i[win*BE_WIDTH +: BE_WIDTH];
      data_ID_o[win] = 1'b1;
      if (data_gnt_i) data_gnt_o[win] = 1'b1;
    end
  end

  assign data_r_valid_o = data_r_valid_i ? data_r_ID_i[N_MASTER-1:0] : '0;

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (win == IDX_W'(N_MASTER-1)) ? '0 : win + IDX_W'(1);
  end

  // An unanswered request locks its winner; a dropped lock may immediately re-lock on a new winner.
  assign lock_d     = req & ~data_gnt_i;
  assign lock_idx_d = req ? win : lock_idx_q;
  assign err_d      = err_q | lock_drop | spur_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      err_q      <= err_d;
    end
  end

  assign err_o = err_q;

`ifdef BRIDGE_ARB_CREDIT_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING+1);

  logic [N_MASTER-1:0] spur;

  for (genvar g = 0; g < N_MASTER; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic             inc, dec;

    assign inc        = hs & (win == IDX_W'(g));
    assign dec        = data_r_valid_i & data_r_ID_i[g];
    assign blocked[g] = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign spur[g]    = dec & (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (inc && !dec) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (dec && !inc && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign spur_err = |spur;
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_OUTSTANDING == 0);
  assign blocked    = '0;
  assign spur_err   = 1'b0;
`endif

endmodule

// File: tb/tb_bridge_rr_arbiter_ctrl.sv
// Directed self-checking bench for bridge_rr_arbiter_ctrl (16-master instance plus a 5-master instance).
module tb_bridge_rr_arbiter_ctrl;

`ifdef BRIDGE_ARB_CREDIT_LIMIT_EN
  localparam bit CREDIT = 1'b1;
`else
  localparam bit CREDIT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  always #5 clk = ~clk;

  logic [15:0]  req_i, gnt_o, id_o, rid_i, rv_o;
  logic [511:0] add_i, wdata_i;
  logic [15:0]  wen_i;
  logic [63:0]  be_i;
  logic         req_o, wen_o, gnt_i, rv_i, err_o;
  logic [31:0]  add_o, wdata_o;
  logic [3:0]   be_o;

  logic [4:0]   f_req_i, f_gnt_o, f_id_o, f_rid_i, f_rv_o, f_wen_i, f_be_i;
  logic [39:0]  f_add_i, f_wdata_i;
  logic         f_req_o, f_wen_o, f_gnt_i, f_rv_i, f_err_o;
  logic [7:0]   f_add_o, f_wdata_o;
  logic [0:0]   f_be_o;

  bridge_rr_arbiter_ctrl #(.N_MASTER(16), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(req_i), .data_add_i(add_i), .data_wen_i(wen_i),
    .data_wdata_i(wdata_i), .data_be_i(be_i), .data_gnt_o(gnt_o),
    .data_req_o(req_o), .data_add_o(add_o), .data_wen_o(wen_o),
    .data_wdata_o(wdata_o), .data_be_o(be_o), .data_ID_o(id_o),
    .data_gnt_i(gnt_i), .data_r_valid_i(rv_i), .data_r_ID_i(rid_i),
    .data_r_valid_o(rv_o), .err_o(err_o)
  );

  bridge_rr_arbiter_ctrl #(.N_MASTER(5), .ADDR_WIDTH(8), .DATA_WIDTH(8), .MAX_OUTSTANDING(4)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(f_req_i), .data_add_i(f_add_i), .data_wen_i(f_wen_i),
    .data_wdata_i(f_wdata_i), .data_be_i(f_be_i), .data_gnt_o(f_gnt_o),
    .data_req_o(f_req_o), .data_add_o(f_add_o), .data_wen_o(f_wen_o),
    .data_wdata_o(f_wdata_o), .data_be_o(f_be_o), .data_ID_o(f_id_o),
    .data_gnt_i(f_gnt_i), .data_r_valid_i(f_rv_i), .data_r_ID_i(f_rid_i),
    .data_r_valid_o(f_rv_o), .err_o(f_err_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; gnt_i = 1'b0; rv_i = 1'b0; rid_i = '0;
    f_req_i = '0; f_gnt_i = 1'b0; f_rv_i = 1'b0; f_rid_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int m = 0; m < 16; m++) begin
      add_i[m*32 +: 32]   = 32'h1000_0000 + 32'(m);
      wdata_i[m*32 +: 32] = 32'hA5A5_0000 + 32'(m);
      be_i[m*4 +: 4]      = 4'(m);
      wen_i[m]            = 1'(m % 2);
    end
    for (int m = 0; m < 5; m++) begin
      f_add_i[m*8 +: 8]   = 8'h40 + 8'(m);
      f_wdata_i[m*8 +: 8] = 8'h80 + 8'(m);
      f_be_i[m]           = 1'b1;
      f_wen_i[m]          = 1'b0;
    end
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_req", 64'(req_o), 64'h0);
    chk("rst_gnt", 64'(gnt_o), 64'h0);
    chk("rst_id", 64'(id_o), 64'h0);
    chk("rst_add", 64'(add_o), 64'h0);
    chk("rst_rv", 64'(rv_o), 64'h0);
    chk("rst_err", 64'(err_o), 64'h0);

    // Round robin under full load: 0..15 then 0 again
    req_i = 16'hFFFF; gnt_i = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      chk("rr_gnt", 64'(gnt_o), 64'(1) << (k % 16));
      chk("rr_id", 64'(id_o), 64'(1) << (k % 16));
      chk("rr_add", 64'(add_o), 64'h1000_0000 + 64'(k % 16));
      tick();
    end

    // Return credits (master 0 holds two)
    req_i = '0; gnt_i = 1'b0; rv_i = 1'b1; rid_i = 16'hFFFF;
    #1;
    chk("rsp_route_all", 64'(rv_o), 64'hFFFF);
    tick();
    rid_i = 16'h0001;
    #1;
    chk("rsp_route_m0", 64'(rv_o), 64'h0001);
    tick();
    rv_i = 1'b0; rid_i = '0;
    #1;
    chk("rsp_no_err", 64'(err_o), 64'h0);
    chk("rsp_idle", 64'(rv_o), 64'h0);

    // Lock holds master 3 even when master 2 (next by rr) joins
    req_i = 16'h0028; gnt_i = 1'b0;
    #1;
    chk("lock_id0", 64'(id_o), 64'h0008);
    chk("lock_add0", 64'(add_o), 64'h1000_0003);
    chk("lock_wen", 64'(wen_o), 64'h1);
    chk("lock_wdata", 64'(wdata_o), 64'hA5A5_0003);
    chk("lock_be", 64'(be_o), 64'h3);
    tick();
    req_i = 16'h002C;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lock_id", 64'(id_o), 64'h0008);
      chk("lock_add", 64'(add_o), 64'h1000_0003);
      chk("lock_nogrant", 64'(gnt_o), 64'h0);
      tick();
    end
    gnt_i = 1'b1;
    #1;
    chk("lock_release", 64'(gnt_o), 64'h0008);
    tick();
    req_i = 16'h0028;
    #1;
    chk("lock_next", 64'(gnt_o), 64'h0020);
    tick();
    chk("lock_err", 64'(err_o), 64'h0);

    // Credit limit on master 2
    do_reset();
    req_i = 16'h0004; gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("cred_gnt", 64'(gnt_o), 64'h0004);
      tick();
    end
    #1;
    chk("cred_block_gnt", 64'(gnt_o), CREDIT ? 64'h0 : 64'h0004);
    chk("cred_block_req", 64'(req_o), CREDIT ? 64'h0 : 64'h1);
    tick();
    req_i = 16'h0084;
    #1;
    chk("cred_other", 64'(gnt_o), 64'h0080);
    tick();
    req_i = 16'h0004; gnt_i = 1'b0; rv_i = 1'b1; rid_i = 16'h0004;
    #1;
    chk("cred_rsp_route", 64'(rv_o), 64'h0004);
    chk("cred_rsp_req", 64'(req_o), CREDIT ? 64'h0 : 64'h1);
    tick();
    rv_i = 1'b0; rid_i = '0; gnt_i = 1'b1;
    #1;
    chk("cred_freed", 64'(gnt_o), 64'h0004);
    tick();

    // Simultaneous grant and response on master 1 at count 2
    do_reset();
    req_i = 16'h0002; gnt_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("sim_pre", 64'(gnt_o), 64'h0002);
      tick();
    end
    rv_i = 1'b1; rid_i = 16'h0002;
    #1;
    chk("sim_both", 64'(gnt_o), 64'h0002);
    tick();
    rv_i = 1'b0; rid_i = '0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("sim_post", 64'(gnt_o), 64'h0002);
      tick();
    end
    #1;
    chk("sim_limit", 64'(gnt_o), CREDIT ? 64'h0 : 64'h0002);
    chk("sim_err", 64'(err_o), 64'h0);
    tick();

    // Spurious response, then lock-drop violation
    do_reset();
    rv_i = 1'b1; rid_i = 16'h0001;
    #1;
    chk("spur_route", 64'(rv_o), 64'h0001);
    chk("spur_err_pre", 64'(err_o), 64'h0);
    tick();
    rv_i = 1'b0; rid_i = '0;
    #1;
    chk("spur_err", 64'(err_o), CREDIT ? 64'h1 : 64'h0);
    tick();
    chk("spur_sticky", 64'(err_o), CREDIT ? 64'h1 : 64'h0);
    req_i = 16'h0001; gnt_i = 1'b0;
    #1;
    chk("drop_req", 64'(req_o), 64'h1);
    tick();
    req_i = '0;
    #1;
    tick();
    chk("drop_err", 64'(err_o), 64'h1);
    tick();
    chk("drop_sticky", 64'(err_o), 64'h1);

    // Five-master instance: wrap from 4 to 0 and asynchronous reset mid-lock
    do_reset();
    f_req_i = 5'b00001; f_gnt_i = 1'b0;
    #1;
    chk("n5_id0", 64'(f_id_o), 64'h01);
    tick();
    f_req_i = '0;
    #1;
    chk("n5_drop_req", 64'(f_req_o), 64'h0);
    chk("n5_err_pre", 64'(f_err_o), 64'h0);
    tick();
    chk("n5_err", 64'(f_err_o), 64'h1);
    f_req_i = 5'b00100; f_gnt_i = 1'b1;
    #1;
    chk("n5_g2", 64'(f_gnt_o), 64'h04);
    tick();
    f_req_i = 5'b10000;
    #1;
    chk("n5_g4", 64'(f_gnt_o), 64'h10);
    chk("n5_add4", 64'(f_add_o), 64'h44);
    tick();
    f_req_i = 5'b11111;
    #1;
    chk("n5_wrap", 64'(f_gnt_o), 64'h01);
    tick();
    f_req_i = 5'b00010;
    #1;
    chk("n5_g1", 64'(f_gnt_o), 64'h02);
    tick();
    f_req_i = 5'b01010; f_gnt_i = 1'b0;
    #1;
    chk("n5_lock_win", 64'(f_id_o), 64'h08);
    tick();
    #1;
    chk("n5_locked", 64'(f_id_o), 64'h08);
    chk("n5_locked_gnt", 64'(f_gnt_o), 64'h0);
    rst_n = 1'b0;
    #1;
    chk("n5_async_id", 64'(f_id_o), 64'h02);
    chk("n5_async_err", 64'(f_err_o), 64'h0);
    chk("main_async_err", 64'(err_o), 64'h0);
    rst_n = 1'b1;
    clear_inputs();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
